// File: rtl/half_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// half_subtractor_pkg
//   Shared constants and helpers for the registered half subtractor.
//   - HS_WIDTH_DEF : default number of independent subtractor lanes
//   - HS_CNT_W_DEF : default width of the optional borrow-event counter
//   - hs_sat_max() : all-ones saturation value for a counter of given width
// ----------------------------------------------------------------------------
package half_subtractor_pkg;

    localparam int unsigned HS_WIDTH_DEF = 1;
    localparam int unsigned HS_CNT_W_DEF = 16;

    // Largest value representable in cnt_w bits (cnt_w in 1..32).
    // A 32-bit counter would overflow the shift, so it is handled separately.
    function automatic logic [31:0] hs_sat_max(input int unsigned cnt_w);
        if (cnt_w >= 32) begin
            return '1;
        end
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage : half_subtractor_pkg

// File: rtl/half_subtractor_cell.sv
// ----------------------------------------------------------------------------
// half_subtractor_cell
//   Single-bit combinational half subtractor, a - b without borrow-in.
//   Ports:
//     a  : minuend bit
//     b  : subtrahend bit
//     d  : difference, a ^ b
//     bo : borrow-out, ~a & b
// ----------------------------------------------------------------------------
module half_subtractor_cell
    import half_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = a ^ b;
        bo = ~a & b;
    end

endmodule : half_subtractor_cell

// File: rtl/half_subtractor.sv
// ----------------------------------------------------------------------------
// half_subtractor
//   Registered bitwise half subtractor. Each of WIDTH independent lanes
//   computes Diff = A ^ B and Borrow = ~A & B; results are registered and
//   appear one clock after the operands are sampled. No lane-to-lane borrow.
//
//   Optional feature (macro HALF_SUBTRACTOR_BORROW_CNT_EN):
//     adds borrow_cnt, a saturating count of clock edges on which the value
//     being registered into Borrow is nonzero.
//
//   Parameters:
//     WIDTH : number of lanes, 1..64
//     CNT_W : borrow-event counter width, 1..32 (used only with the macro)
//   Ports:
//     clk        : clock, all state updates on the rising edge
//     rst_n      : synchronous active-low reset
//     A          : minuend bits, one per lane
//     B          : subtrahend bits, one per lane
//     Diff       : registered difference
//     Borrow     : registered borrow-out
//     borrow_cnt : saturating borrow-event count (macro builds only)
// ----------------------------------------------------------------------------
module half_subtractor
    import half_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = HS_WIDTH_DEF,
    parameter int unsigned CNT_W = HS_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    output logic [WIDTH-1:0] Borrow,
    output logic [CNT_W-1:0] borrow_cnt
`else
    output logic [WIDTH-1:0] Borrow
`endif
);

    logic [WIDTH-1:0] diff_comb;
    logic [WIDTH-1:0] borrow_comb;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_subtractor_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .d  (diff_comb[i]),
            .bo (borrow_comb[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Diff   <= '0;
            Borrow <= '0;
        end else begin
            Diff   <= diff_comb;
            Borrow <= borrow_comb;
        end
    end

`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(hs_sat_max(CNT_W));

    logic any_borrow;

    // Counts from the combinational borrow so it tracks the value being
    // registered this edge, not the one already on Borrow.
    always_comb begin
        any_borrow = |borrow_comb;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            borrow_cnt <= '0;
        end else if (any_borrow && (borrow_cnt != CNT_MAX)) begin
            borrow_cnt <= borrow_cnt + CNT_W'(1);
        end
    end
`endif

endmodule : half_subtractor

// File: tb/tb_half_subtractor.sv
// ----------------------------------------------------------------------------
// tb_half_subtractor
//   Directed bench for half_subtractor. Two instances share clock and reset:
//   u_dut1 (WIDTH=1, CNT_W=16) for the truth-table sweep and mid-stream reset,
//   u_dut4 (WIDTH=4, CNT_W=3) for lane independence and counter saturation.
//   Counter checks are compiled only with HALF_SUBTRACTOR_BORROW_CNT_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_half_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] a1, b1;
    logic [0:0] d1, bo1;
    logic [3:0] a4, b4;
    logic [3:0] d4, bo4;
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    logic [15:0] cnt1;
    logic [2:0]  cnt4;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    half_subtractor #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (a1),
        .B          (b1),
        .Diff       (d1),
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
        .Borrow     (bo1),
        .borrow_cnt (cnt1)
`else
        .Borrow     (bo1)
`endif
    );

    half_subtractor #(.WIDTH(4), .CNT_W(3)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (a4),
        .B          (b4),
        .Diff       (d4),
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
        .Borrow     (bo4),
        .borrow_cnt (cnt4)
`else
        .Borrow     (bo4)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=1 vector: apply a/b, clock, check registered result.
    task automatic vec1(input logic a, input logic b,
                        input logic exp_d, input logic exp_bo);
        a1 = a;
        b1 = b;
        tick();
        check_eq("sweep_diff",   64'(d1),  64'(exp_d));
        check_eq("sweep_borrow", 64'(bo1), 64'(exp_bo));
    endtask

    task automatic vec4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_d, input logic [3:0] exp_bo);
        a4 = a;
        b4 = b;
        tick();
        check_eq("lane_diff",   64'(d4),  64'(exp_d));
        check_eq("lane_borrow", 64'(bo4), 64'(exp_bo));
    endtask

    initial begin
        // Reset with operands that would otherwise produce Diff=0, Borrow=0
        // on every lane except where B forces a borrow on dut4.
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        a4 = 4'h0; b4 = 4'hF;
        #2;
        tick();
        tick();
        check_eq("rst_diff1",   64'(d1),  64'd0);
        check_eq("rst_borrow1", 64'(bo1), 64'd0);
        check_eq("rst_diff4",   64'(d4),  64'd0);
        check_eq("rst_borrow4", 64'(bo4), 64'd0);
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
        check_eq("rst_cnt1", 64'(cnt1), 64'd0);
        check_eq("rst_cnt4", 64'(cnt4), 64'd0);
`endif

        // Release reset; dut4 idles on zeros so its counter stays at 0.
        rst_n = 1'b1;
        a4 = 4'h0; b4 = 4'h0;

        // Truth table, WIDTH=1.
        vec1(1'b0, 1'b0, 1'b0, 1'b0);
        vec1(1'b0, 1'b1, 1'b1, 1'b1);
        vec1(1'b1, 1'b0, 1'b1, 1'b0);
        vec1(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
        check_eq("sweep_cnt1", 64'(cnt1), 64'd1);
        check_eq("idle_cnt4",  64'(cnt4), 64'd0);
`endif

        // Lane independence, WIDTH=4.
        vec4(4'b0101, 4'b0011, 4'b0110, 4'b0010);
        vec4(4'hF,    4'h0,    4'hF,    4'h0);
        vec4(4'h0,    4'hF,    4'hF,    4'hF);
        vec4(4'hA,    4'hA,    4'h0,    4'h0);
        vec4(4'b1100, 4'b1010, 4'b0110, 4'b0010);
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
        check_eq("lane_cnt4", 64'(cnt4), 64'd3);
`endif

        // Mid-stream reset: three borrow cycles, then reset with the
        // borrowing operands still applied.
        a1 = 1'b0; b1 = 1'b1;
        a4 = 4'h0; b4 = 4'h1;
        tick(); tick(); tick();
        check_eq("mid_borrow1", 64'(bo1), 64'd1);
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
        check_eq("mid_cnt1", 64'(cnt1), 64'd4);
`endif
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_diff1",   64'(d1),  64'd0);
        check_eq("mid_rst_borrow1", 64'(bo1), 64'd0);
        check_eq("mid_rst_diff4",   64'(d4),  64'd0);
        check_eq("mid_rst_borrow4", 64'(bo4), 64'd0);
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
        check_eq("mid_rst_cnt1", 64'(cnt1), 64'd0);
        check_eq("mid_rst_cnt4", 64'(cnt4), 64'd0);
`endif

        // Saturation on the 3-bit counter; dut1 idles on zeros.
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'h0; b4 = 4'h1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq("sat_borrow4", 64'(bo4), 64'h1);
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
            check_eq("sat_cnt4", 64'(cnt4), 64'((i < 7) ? i : 7));
`endif
        end
        // No borrow: saturated count holds.
        a4 = 4'h3; b4 = 4'h1;
        tick();
        check_eq("hold_diff4",   64'(d4),  64'h2);
        check_eq("hold_borrow4", 64'(bo4), 64'h0);
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
        check_eq("hold_cnt4", 64'(cnt4), 64'd7);
        check_eq("idle_cnt1", 64'(cnt1), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_half_subtractor

// File: doc/half_subtractor.md
# half_subtractor

Registered bitwise half subtractor: computes Diff = A − B per bit and its Borrow, one clock after sampling the operands. It is a leaf arithmetic block used by datapath logic that needs single-bit subtraction without borrow-in. An optional saturating borrow-event counter supports debug and visibility.

## Interface
- WIDTH, 1, number of independent one-bit subtractor lanes; legal range 1..64.
- CNT_W, 16, width of the optional borrow-event counter; legal range 1..32.

- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low; sampled on rising edge of clk.
- A  in  WIDTH  minuend bits, one per lane.
- B  in  WIDTH  subtrahend bits, one per lane.
- Diff  out  WIDTH  registered difference, A XOR B per lane.
- Borrow  out  WIDTH  registered borrow-out, (NOT A) AND B per lane.
- borrow_cnt  out  CNT_W  saturating count of cycles with any borrow; present only with HALF_SUBTRACTOR_BORROW_CNT_EN.

## Operation
- Lane i is independent: Diff[i] = A[i] ^ B[i]; Borrow[i] = ~A[i] & B[i].
- Truth table per lane (A,B → Diff,Borrow): 00→0,0; 01→1,1; 10→1,0; 11→0,0.
- No handshake. Operands are sampled every cycle, and outputs update every cycle.
- No borrow-in exists. Lanes never propagate into each other.
- X/Z on inputs is not filtered. Outputs follow the bitwise operators.
- Counter, when compiled in, works as follows:
  - It increments by 1 on each rising edge where rst_n=1 and |(~A & B) is 1, i.e. where the Borrow being registered is nonzero.
  - It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Latency is 1 cycle. Outputs at edge n+1 reflect A/B sampled at edge n.
- Reset behaviour:
  - On a rising edge with rst_n=0, Diff=0, Borrow=0 and borrow_cnt=0 on the next edge. This overrides any operand values.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid result appears one edge after the first edge that samples rst_n=1.
- Outputs are glitch-free registers. There is no combinational path from A/B to any output.
- When the counter is at saturation and a borrow occurs in the same cycle, it holds its value.
- When reset and a borrow occur in the same cycle, reset wins and the counter becomes 0.

## Configuration
- Macro: HALF_SUBTRACTOR_BORROW_CNT_EN.
- When defined:
  - The borrow_cnt port exists.
  - The counter register is implemented as described above.
- When undefined:
  - The borrow_cnt port and its logic are absent.
  - Diff/Borrow behaviour is identical to the defined case.

## Structure
- Package half_subtractor_pkg holds:
  - default constants HS_WIDTH_DEF=1 and HS_CNT_W_DEF=16;
  - the saturation-max helper function for CNT_W.
- Sub-module half_subtractor_cell:
  - combinational, one bit wide: inputs a, b; outputs d, bo;
  - instantiated WIDTH times in a generate loop.
- The top holds the output registers and the optional counter.

## Test plan
- Reset check: rst_n=0 for 2 edges with A=1, B=1 → Diff=0, Borrow=0, borrow_cnt=0.
- Exhaustive sweep, WIDTH=1: apply A,B=00,01,10,11 on consecutive edges → one edge later Diff,Borrow=00,11,10,00. borrow_cnt=1 after the sequence.
- Lane independence, WIDTH=4: A=4'b0101, B=4'b0011 → next edge Diff=4'b0110, Borrow=4'b0010.
- Mid-stream reset: A=0, B=1 for 3 edges, then rst_n=0 for 1 edge → Diff=Borrow=0 after that edge, and borrow_cnt=0.
- Saturation, CNT_W=3: hold A=0, B=1 for 10 edges → borrow_cnt reaches 7 and stays 7.
- Macro off: build without HALF_SUBTRACTOR_BORROW_CNT_EN and rerun the sweep → identical Diff/Borrow, and no borrow_cnt port.
